// File: rtl/key_debounce_pkg.sv
// Shared types and parameter validation for the key debounce array.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } key_state_e;

    function automatic bit params_ok(input int n_ch, input int deb_cyc, input int long_cyc,
                                     input int rep_cyc, input int active_low);
        return (n_ch >= 1) && (n_ch <= 32) && (deb_cyc >= 2) && (long_cyc > deb_cyc) &&
               (rep_cyc >= 1) && ((active_low == 0) || (active_low == 1));
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: synchronizer, debouncer and press/long/repeat event FSM.
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DEB_CYC    = 1000000,
    parameter int LONG_CYC   = 50000000,
    parameter int REP_CYC    = 10000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    input  logic rep_en,
    output logic level,
    output logic press_evt,
    output logic release_evt,
    output logic long_evt,
    output logic repeat_evt
);

    localparam int   DEB_W    = $clog2(DEB_CYC + 1);
    localparam int   HOLD_W   = $clog2(LONG_CYC + 1);
    localparam int   REP_W    = $clog2(REP_CYC + 1);
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    logic              sync_p0, sync_p1;
    logic [DEB_W-1:0]  deb_cnt;
    logic              pressed, mismatch, flip, press_now, release_now;
    key_state_e        state, state_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [REP_W-1:0]  rep_cnt, rep_n;
    logic              long_n, repeat_n;

    // Stage p0/p1: two-flop synchronizer, reset to the released key level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= IDLE_LVL;
            sync_p1 <= IDLE_LVL;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed     = sync_p1 ^ IDLE_LVL;
    assign mismatch    = (pressed != level);
    assign flip        = mismatch && (deb_cnt == DEB_W'(DEB_CYC - 1));
    assign press_now   = flip && !level;
    assign release_now = flip && level;

    // Debounce stage: level flips on the cycle the mismatch run reaches DEB_CYC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            level   <= 1'b0;
        end else if (flip) begin
            deb_cnt <= '0;
            level   <= ~level;
        end else if (mismatch) begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end else begin
            deb_cnt <= '0;
        end
    end

    always_comb begin
        state_n  = state;
        hold_n   = hold_cnt;
        rep_n    = rep_cnt;
        long_n   = 1'b0;
        repeat_n = 1'b0;
        case (state)
            IDLE: begin
                hold_n = '0;
                rep_n  = '0;
                if (press_now) state_n = HELD;
            end
            HELD: begin
                if (release_now) begin
                    state_n = IDLE;
                    hold_n  = '0;
                end else if (hold_cnt == HOLD_W'(LONG_CYC - 1)) begin
                    state_n = LONG;
                    hold_n  = HOLD_W'(LONG_CYC);
                    long_n  = 1'b1;
                end else begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            LONG: begin
                // Release wins over any repeat due in the same cycle
                if (release_now) begin
                    state_n = IDLE;
                    hold_n  = '0;
                    rep_n   = '0;
                end else if (!rep_en) begin
                    rep_n = '0;
                end else if (rep_cnt == REP_W'(REP_CYC - 1)) begin
                    rep_n    = '0;
                    repeat_n = 1'b1;
                end else begin
                    rep_n = rep_cnt + REP_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                hold_n  = '0;
                rep_n   = '0;
            end
        endcase
    end

    // Event stage: pulses registered so they line up with the new level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            long_evt    <= 1'b0;
            repeat_evt  <= 1'b0;
        end else begin
            state       <= state_n;
            hold_cnt    <= hold_n;
            rep_cnt     <= rep_n;
            press_evt   <= press_now;
            release_evt <= release_now;
            long_evt    <= long_n;
            repeat_evt  <= repeat_n;
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// Array of independent debounced key channels with press/release/long/repeat events.
module key_debounce_array
    import key_debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DEB_CYC    = 1000000,
    parameter int LONG_CYC   = 50000000,
    parameter int REP_CYC    = 10000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_key,
    input  logic [N_CH-1:0] i_rep_en,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long,
    output logic [N_CH-1:0] o_repeat
);

    if (!params_ok(N_CH, DEB_CYC, LONG_CYC, REP_CYC, ACTIVE_LOW)) begin : g_bad_params
        $error("key_debounce_array: illegal parameters N_CH=%0d DEB_CYC=%0d LONG_CYC=%0d REP_CYC=%0d ACTIVE_LOW=%0d",
               N_CH, DEB_CYC, LONG_CYC, REP_CYC, ACTIVE_LOW);
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        key_debounce_channel #(
            .DEB_CYC    (DEB_CYC),
            .LONG_CYC   (LONG_CYC),
            .REP_CYC    (REP_CYC),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_channel (
            .clk         (i_clk),
            .rst_n       (i_rst_n),
            .key_raw     (i_key[ch]),
            .rep_en      (i_rep_en[ch]),
            .level       (o_level[ch]),
            .press_evt   (o_press[ch]),
            .release_evt (o_release[ch]),
            .long_evt    (o_long[ch]),
            .repeat_evt  (o_repeat[ch])
        );
    end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: directed scenarios plus random key activity vs a timing model.
module tb_key_debounce_array;

    localparam int N    = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key = '1;
    logic [N-1:0] rep_en = '0;
    logic [N-1:0] o_level, o_press, o_release, o_long, o_repeat;

    key_debounce_array #(
        .N_CH(N), .DEB_CYC(DEB), .LONG_CYC(LONG), .REP_CYC(REP), .ACTIVE_LOW(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .i_rep_en(rep_en),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_long(o_long), .o_repeat(o_repeat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pressed samples seen 2 edges late, a streak count per channel,
    // and absolute edge timestamps for press and last repeat reference.
    int           cyc = 0;
    int           m_s0[N], m_s1[N], m_run[N], m_lvl[N];
    int           m_press_t[N], m_long_done[N], m_rep_ref[N];
    logic [N-1:0] e_level, e_press, e_rel, e_long, e_rep;
    logic [N-1:0] acc_pulse, acc_level, acc_long;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_s0[c] = 0; m_s1[c] = 0; m_run[c] = 0; m_lvl[c] = 0;
            m_press_t[c] = -1; m_long_done[c] = 0; m_rep_ref[c] = 0;
        end
        e_level = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    endtask

    task automatic model_step();
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int c = 0; c < N; c++) begin
            bit evt = 0;
            if (m_s1[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_run[c] = 0;
                    m_lvl[c] = 1 - m_lvl[c];
                    evt = 1;
                    if (m_lvl[c] == 1) begin
                        e_press[c] = 1'b1; m_press_t[c] = cyc; m_long_done[c] = 0;
                    end else begin
                        e_rel[c] = 1'b1; m_press_t[c] = -1;
                    end
                end
            end else begin
                m_run[c] = 0;
            end
            if (!evt && m_press_t[c] >= 0) begin
                if (!m_long_done[c]) begin
                    if (cyc - m_press_t[c] == LONG) begin
                        e_long[c] = 1'b1; m_long_done[c] = 1; m_rep_ref[c] = cyc;
                    end
                end else if (!rep_en[c]) begin
                    m_rep_ref[c] = cyc;
                end else if (cyc - m_rep_ref[c] == REP) begin
                    e_rep[c] = 1'b1; m_rep_ref[c] = cyc;
                end
            end
            m_s1[c] = m_s0[c];
            m_s0[c] = key[c] ? 0 : 1;
            e_level[c] = m_lvl[c][0];
        end
        cyc++;
    endtask

    task automatic check_all();
        check("level",   o_level,   e_level);
        check("press",   o_press,   e_press);
        check("release", o_release, e_rel);
        check("long",    o_long,    e_long);
        check("repeat",  o_repeat,  e_rep);
    endtask

    task automatic cycle(input logic [N-1:0] k, input logic [N-1:0] re);
        key = k; rep_en = re;
        model_step();
        @(posedge clk); #1;
        check_all();
        acc_pulse |= o_press | o_release | o_long | o_repeat;
        acc_level |= o_level;
        acc_long  |= o_long;
    endtask

    task automatic run(input logic [N-1:0] k, input logic [N-1:0] re, input int n);
        for (int i = 0; i < n; i++) cycle(k, re);
    endtask

    task automatic reset_dut(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] rk, rr;
        model_reset();
        #2;
        reset_dut(3);
        run(2'b11, 2'b00, 10);

        // Single press: level and press pulse on the 6th edge after the key edge
        run(2'b10, 2'b01, 5);
        check("a_level_early", o_level[0], 1'b0);
        cycle(2'b10, 2'b01);
        check("a_press", o_press, 2'b01);
        check("a_level", o_level[0], 1'b1);
        acc_long = '0;
        run(2'b10, 2'b01, 19);
        check("a_long_early", acc_long, 2'b00);
        cycle(2'b10, 2'b01);
        check("a_long", o_long, 2'b01);
        for (int r = 0; r < 3; r++) begin
            run(2'b10, 2'b01, 4);
            cycle(2'b10, 2'b01);
            check("a_repeat", o_repeat, 2'b01);
        end
        run(2'b11, 2'b01, 5);
        cycle(2'b11, 2'b01);
        check("a_release", o_release, 2'b01);
        check("a_rel_no_rep", o_repeat | o_long, 2'b00);
        acc_pulse = '0;
        run(2'b11, 2'b01, 30);
        check("a_quiet_after", acc_pulse, 2'b00);

        // Short glitch is ignored
        acc_pulse = '0; acc_level = '0;
        run(2'b10, 2'b00, 3);
        run(2'b11, 2'b00, 10);
        check("b_glitch", {acc_pulse, acc_level}, 4'b0000);

        // Release one edge before the long press would fire
        run(2'b10, 2'b00, 5);
        cycle(2'b10, 2'b00);
        check("c_press", o_press, 2'b01);
        acc_long = '0;
        run(2'b10, 2'b00, 13);
        run(2'b11, 2'b00, 5);
        cycle(2'b11, 2'b00);
        check("c_release", o_release, 2'b01);
        run(2'b11, 2'b00, 10);
        check("c_no_long", acc_long, 2'b00);

        // Both channels together, repeat enabled on channel 0 only
        run(2'b00, 2'b01, 5);
        cycle(2'b00, 2'b01);
        check("d_press", o_press, 2'b11);
        run(2'b00, 2'b01, 19);
        cycle(2'b00, 2'b01);
        check("d_long", o_long, 2'b11);
        run(2'b00, 2'b01, 4);
        cycle(2'b00, 2'b01);
        check("d_repeat", o_repeat, 2'b01);
        run(2'b11, 2'b01, 5);
        cycle(2'b11, 2'b01);
        check("d_release", o_release, 2'b11);
        run(2'b11, 2'b00, 10);

        // Key held low across reset counts as a fresh press
        key = 2'b10;
        reset_dut(4);
        check("e_rst_out", {o_level, o_press, o_release, o_long, o_repeat}, 10'd0);
        run(2'b10, 2'b00, 5);
        check("e_press_early", o_press, 2'b00);
        cycle(2'b10, 2'b00);
        check("e_press", o_press, 2'b01);
        run(2'b11, 2'b00, 10);

        // Random key activity, repeat enables and occasional mid-operation reset
        rk = 2'b11; rr = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(24) == 0) rk[c] = ~rk[c];
                if ($urandom_range(40) == 0) rr[c] = ~rr[c];
            end
            if ($urandom_range(600) == 0) begin
                key = rk;
                reset_dut($urandom_range(1, 3));
            end
            if ($urandom_range(30) == 0) run(rk ^ 2'($urandom_range(1, 3)), rr, $urandom_range(1, 3));
            else cycle(rk, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent key channels (1..32).
REQ-002 SHALL have parameter DEB_CYC, default 1000000: cycles a synchronized input must differ from the debounced level before the level flips (>=2).
REQ-003 SHALL have parameter LONG_CYC, default 50000000: held-cycles from press pulse to long-press pulse (>DEB_CYC).
REQ-004 SHALL have parameter REP_CYC, default 10000000: auto-repeat period after long press (>=1).
REQ-005 SHALL have parameter ACTIVE_LOW, default 1: 1 = raw key reads 0 when pressed.
REQ-006 SHALL have port i_clk, input, 1, clock.
REQ-007 SHALL have port i_rst_n, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have port i_key, input, N_CH, raw asynchronous key levels.
REQ-009 SHALL have port i_rep_en, input, N_CH, per-channel auto-repeat enable.
REQ-010 SHALL have port o_level, output, N_CH, debounced pressed level (1 = pressed).
REQ-011 SHALL have ports o_press, o_release, o_long, o_repeat, output, N_CH each, one-cycle event pulses.

Function
REQ-012 SHALL pass each i_key bit through a 2-flop synchronizer, then normalize polarity to "pressed = 1" per ACTIVE_LOW.
REQ-013 SHALL count consecutive cycles where normalized input != o_level; any equal cycle clears the count to 0.
REQ-014 SHALL toggle o_level when the mismatch count reaches DEB_CYC; count clears in the same cycle; raw-edge-to-o_level latency = DEB_CYC+2 cycles.
REQ-015 SHALL assert o_press (o_release) for exactly one cycle, registered, coincident with the first cycle o_level is 1 (0).
REQ-016 SHALL run a per-channel FSM: IDLE (level 0), HELD (level 1, before long), LONG (level 1, after long); IDLE->HELD on press, HELD->LONG on long event, HELD/LONG->IDLE on release.
REQ-017 SHALL assert o_long once, LONG_CYC cycles after the o_press cycle, if no release occurs first.
REQ-018 SHALL, in LONG with i_rep_en=1, assert o_repeat every REP_CYC cycles, first at LONG_CYC+REP_CYC after o_press; i_rep_en=0 suppresses pulses and holds the repeat counter at 0.
REQ-019 SHALL make release take priority: in the o_release cycle o_long and o_repeat are 0, and hold/repeat counters clear.
REQ-020 SHALL ignore input glitches shorter than DEB_CYC cycles (no level change, no pulses).
REQ-021 SHALL operate channels fully independently; simultaneous events on several channels all appear in the same cycle.
REQ-022 SHALL size counters as $clog2(max+1) bits with no wrap-around; hold counter saturates at LONG_CYC.

Reset
REQ-023 SHALL, while i_rst_n=0, force all outputs to 0, all counters to 0, FSM to IDLE, and synchronizer flops to the released value (ACTIVE_LOW ? 1 : 0).
REQ-024 SHALL treat a key held through reset deassertion as a new press: o_press DEB_CYC+2 cycles after reset release.
REQ-025 SHALL abort any in-progress debounce or hold on reset mid-operation, with no pulse emitted.

Structure
REQ-026 SHALL place the FSM state enum (IDLE/HELD/LONG) and a parameter range-check function in package key_debounce_pkg.
REQ-027 SHALL implement one channel in sub-module key_debounce_channel, instantiated N_CH times via generate.
REQ-028 SHALL flag illegal parameter values with an elaboration-time $error.

Verification (N_CH=2, DEB_CYC=4, LONG_CYC=20, REP_CYC=5, ACTIVE_LOW=1)
REQ-029 SHALL test: i_key[0] 1->0 held -> o_press[0] pulse and o_level[0]=1 exactly 6 cycles after the edge.
REQ-030 SHALL test: i_key[0] low for 3 cycles, then high -> no o_level change, no pulses.
REQ-031 SHALL test: hold with i_rep_en=1 -> o_long at press+20 cycles; o_repeat at +25, +30, +35; release -> o_release, no further pulses.
REQ-032 SHALL test: release at press+19 -> o_release only; o_long never asserts.
REQ-033 SHALL test: both channels pressed on the same cycle -> o_press=2'b11 in one cycle; i_rep_en=2'b01 -> o_repeat only on channel 0.
REQ-034 SHALL test: key held low across reset -> outputs 0 during reset; o_press 6 cycles after i_rst_n rises.
